// File: rtl/matrix_pkg.sv
// Shared types and fixed-point helpers for the sequential matrix multiplier.
package matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int SAT_W = 64;

  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  // Floor-shift by the fraction bits, then clamp into a signed width-bit range.
  function automatic logic signed [SAT_W-1:0] fxp_sat(
    input logic signed [SAT_W-1:0] x,
    input int                      frac,
    input int                      width
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = x >>> frac;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (width - 1));
    if (shifted > hi) begin
      return hi;
    end
    if (shifted < lo) begin
      return lo;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_fxp_mac.sv
// Registered signed multiply-accumulate; acc presents the value the register takes on an enabled edge.
module fxp_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    clear,
  input  logic                    en,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
  assign acc      = clear ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Square fixed-point matrix multiplier: one MAC, one product per cycle, multON/endMult2x2 handshake.
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int nos       = 4,
  parameter int intDigits = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 multON,
  input  logic [0:nos-1][0:nos-1][WIDTH-1:0]   A,
  input  logic [0:nos-1][0:nos-1][WIDTH-1:0]   B,
  output logic [0:nos-1][0:nos-1][WIDTH-1:0]   Res,
  output logic                                 endMult2x2
);

  localparam int FRAC  = WIDTH - intDigits;
  localparam int ACC_W = acc_width(WIDTH, nos);
  localparam int IDX_W = $clog2(nos);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(nos - 1);

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      i_q, i_d, j_q, j_d, k_q, k_d;
  logic [0:nos-1][0:nos-1][WIDTH-1:0]    res_q;
  logic                                  mac_clear, mac_en, res_we;
  logic signed [ACC_W-1:0]               mac_acc;
  logic signed [SAT_W-1:0]               acc_ext, sat_full;
  logic                                  unused_sat_bits;

  fxp_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .a     (A[i_q][k_q]),
    .b     (B[k_q][j_q]),
    .clear (mac_clear),
    .en    (mac_en),
    .acc   (mac_acc)
  );

  assign acc_ext         = {{(SAT_W - ACC_W){mac_acc[ACC_W-1]}}, mac_acc};
  assign sat_full        = fxp_sat(acc_ext, FRAC, WIDTH);
  assign unused_sat_bits = ^sat_full[SAT_W-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    res_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (multON) begin
          state_d = S_ACC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_ACC: begin
        // Dropping the request abandons the job; nothing is written this cycle.
        if (!multON) begin
          state_d = S_IDLE;
        end else begin
          mac_en    = 1'b1;
          mac_clear = (k_q == '0);
          if (k_q == LAST) begin
            res_we = 1'b1;
            k_d    = '0;
            if (j_q == LAST) begin
              j_d = '0;
              if (i_q == LAST) begin
                state_d = S_DONE;
              end else begin
                i_d = i_q + 1'b1;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      if (res_we) begin
        res_q[i_q][j_q] <= sat_full[WIDTH-1:0];
      end
    end
  end

  assign Res        = res_q;
  assign endMult2x2 = (state_q == S_DONE);

endmodule
